// File: rtl/oled_frame_streamer_pkg.sv
// Shared types and command constants for the OLED frame streamer.
package oled_pkg;

  typedef enum logic [3:0] {
    IDLE, CMD, CMD_WAIT, RD, RD_LAT, DAT, DAT_WAIT, NEXT, DONE
  } oled_state_e;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;
  localparam int         CMDS_PER_PAGE = 3;

  // Page-addressing command preamble: page select, then low and high column nibble.
  function automatic logic [7:0] page_cmd(input logic [1:0] idx,
                                          input logic [3:0] page,
                                          input logic [7:0] col_start);
    case (idx)
      2'd0:    return CMD_PAGE_BASE | {4'd0, page};
      2'd1:    return CMD_COL_LO | {4'd0, col_start[3:0]};
      default: return CMD_COL_HI | {4'd0, col_start[7:4]};
    endcase
  endfunction

endpackage

// File: rtl/oled_frame_streamer_if.sv
// Frame-buffer read port plus SPI byte-writer handshake seen by the streamer.
interface oled_frame_streamer_if #(
  parameter int ADDR_W = 10
);
  logic              rden;
  logic [ADDR_W-1:0] rdaddress;
  logic [7:0]        ram_data;
  logic              ena_write;
  logic [7:0]        data;
  logic              oled_dc;
  logic              write_done;

  modport master (
    output rden, rdaddress, ena_write, data, oled_dc,
    input  ram_data, write_done
  );

  modport slave (
    input  rden, rdaddress, ena_write, data, oled_dc,
    output ram_data, write_done
  );
endinterface

// File: rtl/oled_frame_streamer_cursor.sv
// Page/column cursor for the streamer: wrap logic and linear RAM address.
module oled_stream_cursor #(
  parameter int COLS   = 128,
  parameter int PAGES  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [3:0]        page_start_i,
  input  logic [3:0]        page_end_i,
  input  logic [7:0]        col_start_i,
  input  logic [7:0]        col_end_i,
  output logic [3:0]        page_o,
  output logic              last_col_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] addr_next_o
);

  localparam int COL_W = $clog2(COLS);

  logic [3:0] page_q, page_d, nxt_page;
  logic [7:0] col_q, col_d, nxt_col;

  // COLS is a power of two, so page*COLS+col is a shift-and-or.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [3:0] pg, input logic [7:0] cl);
    logic [31:0] a;
    a = (32'(pg) << COL_W) | 32'(cl);
    return a[ADDR_W-1:0];
  endfunction

  assign last_col_o = (col_q == col_end_i);
  assign last_o     = last_col_o && (page_q == page_end_i);

  always_comb begin
    nxt_page = page_q;
    nxt_col  = col_q + 8'd1;
    if (last_col_o) begin
      nxt_col  = col_start_i;
      nxt_page = page_q + 4'd1;
    end
  end

  always_comb begin
    page_d = page_q;
    col_d  = col_q;
    if (load_i) begin
      page_d = page_start_i;
      col_d  = col_start_i;
    end else if (adv_i) begin
      page_d = nxt_page;
      col_d  = nxt_col;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      page_q <= 4'd0;
      col_q  <= 8'd0;
    end else begin
      page_q <= page_d;
      col_q  <= col_d;
    end
  end

  assign page_o      = page_q;
  assign addr_o      = lin_addr(page_q, col_q);
  assign addr_next_o = lin_addr(nxt_page, nxt_col);

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams an OLED frame buffer to an SPI byte writer, page by page.
// Define OLED_STREAM_WIN_EN to add a latched page/column refresh window.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int PAGES  = 8,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic start,
  input  logic cont_mode,
`ifdef OLED_STREAM_WIN_EN
  input  logic [3:0] win_page_start,
  input  logic [3:0] win_page_end,
  input  logic [7:0] win_col_start,
  input  logic [7:0] win_col_end,
`endif
  output logic busy,
  output logic frame_done,
  oled_frame_streamer_if.master bus
);

  oled_state_e       state_q;
  logic [1:0]        cmd_idx_q;
  logic              busy_q, frame_done_q, ena_write_q, dc_q, rden_q;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] rdaddr_q;

  logic [3:0]        ps_sel, pe_sel, cur_page;
  logic [7:0]        cs_sel, ce_sel;
  logic              win_ok, accept, restart, load, adv, last_col, last;
  logic [ADDR_W-1:0] cur_addr, next_addr;

  assign accept  = (state_q == IDLE) && start && init_done;
  assign restart = cont_mode && init_done;
  assign load    = accept || ((state_q == DONE) && restart);
  assign adv     = (state_q == NEXT);

`ifdef OLED_STREAM_WIN_EN
  logic [3:0] win_ps_q, win_pe_q;
  logic [7:0] win_cs_q, win_ce_q;

  function automatic logic win_valid(input logic [3:0] ps, input logic [3:0] pe,
                                     input logic [7:0] cs, input logic [7:0] ce);
    return (ps <= pe) && (cs <= ce) &&
           ({28'd0, pe} < 32'(PAGES)) && ({24'd0, ce} < 32'(COLS));
  endfunction

  // While idle the cursor loads straight from the inputs being latched this cycle.
  assign ps_sel = (state_q == IDLE) ? win_page_start : win_ps_q;
  assign pe_sel = (state_q == IDLE) ? win_page_end   : win_pe_q;
  assign cs_sel = (state_q == IDLE) ? win_col_start  : win_cs_q;
  assign ce_sel = (state_q == IDLE) ? win_col_end    : win_ce_q;
  assign win_ok = win_valid(win_page_start, win_page_end, win_col_start, win_col_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_ps_q <= 4'd0;
      win_pe_q <= 4'd0;
      win_cs_q <= 8'd0;
      win_ce_q <= 8'd0;
    end else if (accept) begin
      win_ps_q <= win_page_start;
      win_pe_q <= win_page_end;
      win_cs_q <= win_col_start;
      win_ce_q <= win_col_end;
    end
  end
`else
  assign ps_sel = 4'd0;
  assign pe_sel = 4'(PAGES - 1);
  assign cs_sel = 8'd0;
  assign ce_sel = 8'(COLS - 1);
  assign win_ok = 1'b1;
`endif

  oled_stream_cursor #(.COLS(COLS), .PAGES(PAGES), .ADDR_W(ADDR_W)) u_cursor (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .adv_i       (adv),
    .page_start_i(ps_sel),
    .page_end_i  (pe_sel),
    .col_start_i (cs_sel),
    .col_end_i   (ce_sel),
    .page_o      (cur_page),
    .last_col_o  (last_col),
    .last_o      (last),
    .addr_o      (cur_addr),
    .addr_next_o (next_addr)
  );

  // rden is raised on entry to RD so the RAM samples it during RD and data is valid in RD_LAT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_idx_q    <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ena_write_q  <= 1'b0;
      dc_q         <= 1'b0;
      data_q       <= 8'd0;
      rden_q       <= 1'b0;
      rdaddr_q     <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q    <= 1'b1;
            cmd_idx_q <= 2'd0;
            state_q   <= win_ok ? CMD : DONE;
          end
        end
        CMD: begin
          data_q      <= page_cmd(cmd_idx_q, cur_page, cs_sel);
          dc_q        <= 1'b0;
          ena_write_q <= 1'b1;
          state_q     <= CMD_WAIT;
        end
        CMD_WAIT: begin
          ena_write_q <= 1'b0;
          if (bus.write_done) begin
            if (cmd_idx_q == 2'(CMDS_PER_PAGE - 1)) begin
              rden_q   <= 1'b1;
              rdaddr_q <= cur_addr;
              state_q  <= RD;
            end else begin
              cmd_idx_q <= cmd_idx_q + 2'd1;
              state_q   <= CMD;
            end
          end
        end
        RD: begin
          rden_q  <= 1'b0;
          state_q <= RD_LAT;
        end
        RD_LAT: begin
          data_q  <= bus.ram_data;
          dc_q    <= 1'b1;
          state_q <= DAT;
        end
        DAT: begin
          ena_write_q <= 1'b1;
          state_q     <= DAT_WAIT;
        end
        DAT_WAIT: begin
          ena_write_q <= 1'b0;
          if (bus.write_done) state_q <= NEXT;
        end
        NEXT: begin
          if (last) begin
            state_q <= DONE;
          end else if (last_col) begin
            cmd_idx_q <= 2'd0;
            state_q   <= CMD;
          end else begin
            rden_q   <= 1'b1;
            rdaddr_q <= next_addr;
            state_q  <= RD;
          end
        end
        DONE: begin
          frame_done_q <= 1'b1;
          if (restart) begin
            cmd_idx_q <= 2'd0;
            state_q   <= CMD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign bus.rden      = rden_q;
  assign bus.rdaddress = rdaddr_q;
  assign bus.ena_write = ena_write_q;
  assign bus.data      = data_q;
  assign bus.oled_dc   = dc_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench for oled_frame_streamer (COLS=16, PAGES=2).
module tb_oled_frame_streamer;
  localparam int COLS   = 16;
  localparam int PAGES  = 2;
  localparam int ADDR_W = 5;
  localparam int NBYTES = PAGES * (3 + COLS);

  logic clk = 1'b0;
  logic rst_n = 1'b0, init_done = 1'b0, start = 1'b0, cont_mode = 1'b0;
  logic busy, frame_done;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  oled_frame_streamer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef OLED_STREAM_WIN_EN
  logic [3:0] wps = 4'd0, wpe = 4'd1;
  logic [7:0] wcs = 8'd0, wce = 8'd15;
`endif

  oled_frame_streamer #(.COLS(COLS), .PAGES(PAGES), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_done     (init_done),
    .start         (start),
    .cont_mode     (cont_mode),
`ifdef OLED_STREAM_WIN_EN
    .win_page_start(wps),
    .win_page_end  (wpe),
    .win_col_start (wcs),
    .win_col_end   (wce),
`endif
    .busy          (busy),
    .frame_done    (frame_done),
    .bus           (bus)
  );

  // RAM with one cycle of read latency, mem[i] = i.
  always @(posedge clk) if (bus.rden) bus.ram_data <= 8'(bus.rdaddress);

  // SPI writer: write_done high 8 cycles after the ena_write cycle.
  logic [3:0] spi_cnt;
  always @(posedge clk) begin
    bus.write_done <= 1'b0;
    if (!rst_n) spi_cnt <= 4'd0;
    else if (bus.ena_write) spi_cnt <= 4'd7;
    else if (spi_cnt != 0) begin
      spi_cnt <= spi_cnt - 4'd1;
      if (spi_cnt == 4'd1) bus.write_done <= 1'b1;
    end
  end

  // Monitor: collects {dc,data} per ena_write and watches the byte handshake.
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int fd_counts[$];
  int fd_total = 0, bytes_since = 0, proto_err = 0, ena_total = 0;
  logic pending = 1'b0;
  logic [8:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (bus.ena_write) begin
        if (pending) proto_err++;
        pending = 1'b1;
        held = {bus.oled_dc, bus.data};
        got_q.push_back(held);
        bytes_since++;
        ena_total++;
      end else if (pending) begin
        if ({bus.oled_dc, bus.data} !== held) proto_err++;
        if (bus.write_done) pending = 1'b0;
      end
      if (frame_done) begin
        fd_total++;
        fd_counts.push_back(bytes_since);
        bytes_since = 0;
      end
    end
  end

  // Reference byte stream computed from the window bounds.
  task automatic build_ref(input int ps, input int pe, input int cs, input int ce);
    exp_q.delete();
    if (ps > pe || cs > ce || pe >= PAGES || ce >= COLS) return;
    for (int p = ps; p <= pe; p++) begin
      exp_q.push_back({1'b0, 8'(176 + p)});
      exp_q.push_back({1'b0, 8'(cs % 16)});
      exp_q.push_back({1'b0, 8'(16 + cs / 16)});
      for (int c = cs; c <= ce; c++) exp_q.push_back({1'b1, 8'(p * COLS + c)});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fd_total >= target) break;
      tick();
    end
    ok = (fd_total >= target);
  endtask

  task automatic clear_mon();
    got_q.delete();
    fd_counts.delete();
    bytes_since = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (bus.ena_write !== 1'b0) begin errors++; $display("FAIL reset_ena_write got=%b exp=0", bus.ena_write); end
    checks++; if (bus.rden !== 1'b0 || bus.rdaddress !== '0) begin errors++;
      $display("FAIL reset_rd got=%b/%h exp=0/0", bus.rden, bus.rdaddress); end
    checks++; if (bus.data !== 8'd0 || bus.oled_dc !== 1'b0) begin errors++;
      $display("FAIL reset_data got=%h/%b exp=00/0", bus.data, bus.oled_dc); end
    rst_n = 1'b1;
    init_done = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_frame();
    bit ok;
    int base, perr;
    clear_mon();
    build_ref(0, PAGES - 1, 0, COLS - 1);
    base = fd_total;
    perr = proto_err;
    repeat ($urandom_range(1, 6)) tick();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_high got=%b exp=1", busy); end
    wait_fd(base + 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=%0d exp=%0d frame_done", fd_total - base, 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    repeat (30) tick();
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), NBYTES); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL single_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_total - base != 1) begin errors++; $display("FAIL single_fd_pulses got=%0d exp=1", fd_total - base); end
    checks++; if (proto_err != perr) begin errors++; $display("FAIL single_handshake got=%0d exp=0 violations", proto_err - perr); end
  endtask

  task automatic test_init_gate();
    int e0;
    e0 = ena_total;
    init_done = 1'b0;
    tick();
    pulse_start();
    repeat (50) begin
      if (busy !== 1'b0) break;
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy got=%b exp=0", busy); end
    checks++; if (ena_total != e0) begin errors++; $display("FAIL gate_ena got=%0d exp=0 writes", ena_total - e0); end
    init_done = 1'b1;
    tick();
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int base;
    clear_mon();
    base = fd_total;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(5, 60)) tick();
      pulse_start();
    end
    wait_fd(base + 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rebusy_timeout got=%0d exp=1 frame_done", fd_total - base); end
    repeat (40) tick();
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL rebusy_count got=%0d exp=%0d", got_q.size(), NBYTES); end
    checks++; if (fd_total - base != 1 || busy !== 1'b0) begin errors++;
      $display("FAIL rebusy_frames got=%0d/%b exp=1/0", fd_total - base, busy); end
  endtask

  task automatic test_cont_mode();
    bit ok;
    int base;
    clear_mon();
    build_ref(0, PAGES - 1, 0, COLS - 1);
    base = fd_total;
    cont_mode = 1'b1;
    pulse_start();
    wait_fd(base + 2, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_timeout got=%0d exp=2 frames", fd_total - base); end
    cont_mode = 1'b0;
    for (int i = 0; i < 2000 && busy !== 1'b0; i++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop got=%b exp=0 busy", busy); end
    checks++; if (fd_counts.size() != 3) begin errors++; $display("FAIL cont_frames got=%0d exp=3", fd_counts.size()); end
    foreach (fd_counts[k]) begin
      checks++;
      if (fd_counts[k] != NBYTES) begin errors++; $display("FAIL cont_len%0d got=%0d exp=%0d", k, fd_counts[k], NBYTES); end
    end
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i % NBYTES]) begin
        checks++; errors++;
        $display("FAIL cont_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i % NBYTES]);
        break;
      end
    end
    checks++; if (got_q.size() < NBYTES + 3 || got_q[NBYTES] !== 9'h0B0) begin errors++;
      $display("FAIL cont_second_frame_head got=%0d bytes exp=B0 at %0d", got_q.size(), NBYTES); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base, n;
    clear_mon();
    build_ref(0, PAGES - 1, 0, COLS - 1);
    pulse_start();
    for (n = 0; n < 1000 && got_q.size() < 20; n++) tick();
    checks++; if (got_q.size() < 20) begin errors++; $display("FAIL midrst_reach got=%0d exp=20 bytes", got_q.size()); end
    repeat ($urandom_range(1, 5)) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, frame_done, bus.ena_write, bus.rden, bus.oled_dc} !== 5'b0 ||
        bus.data !== 8'd0 || bus.rdaddress !== '0) begin errors++;
      $display("FAIL midrst_outputs got=%b%b%b%b%b/%h/%h exp=all zero", busy, frame_done,
               bus.ena_write, bus.rden, bus.oled_dc, bus.data, bus.rdaddress); end
    rst_n = 1'b1;
    tick();
    clear_mon();
    base = fd_total;
    pulse_start();
    wait_fd(base + 1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got=%0d exp=1 frame_done", fd_total - base); end
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), NBYTES); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        checks++; errors++;
        $display("FAIL midrst_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        break;
      end
    end
    checks++; if (got_q.size() == 0 || got_q[0] !== 9'h0B0) begin errors++;
      $display("FAIL midrst_first got=%0d bytes exp=B0 first", got_q.size()); end
  endtask

`ifdef OLED_STREAM_WIN_EN
  task automatic test_window();
    bit ok;
    int base;
    clear_mon();
    wps = 4'd1; wpe = 4'd1; wcs = 8'd4; wce = 8'd7;
    build_ref(1, 1, 4, 7);
    base = fd_total;
    pulse_start();
    wps = 4'd0; wcs = 8'd0;
    wait_fd(base + 1, 1000, ok);
    repeat (10) tick();
    checks++; if (!ok || got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL win_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL win_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    clear_mon();
    wps = 4'd0; wpe = 4'd1; wcs = 8'd9; wce = 8'd3;
    base = fd_total;
    pulse_start();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL winbad_early got=%b exp=0", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL winbad_pulse got=%b exp=1", frame_done); end
    repeat (20) tick();
    checks++; if (got_q.size() != 0 || fd_total - base != 1) begin errors++;
      $display("FAIL winbad_bytes got=%0d/%0d exp=0/1", got_q.size(), fd_total - base); end
    wcs = 8'd0; wce = 8'd15;
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_init_gate();
    test_start_while_busy();
    test_cont_mode();
    test_reset_mid();
`ifdef OLED_STREAM_WIN_EN
    test_window();
`endif
    test_single_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
OLED_FRAME_STREAMER -- requirements
Module: oled_frame_streamer

Interface
REQ-001 The block SHALL have parameter COLS, default 128, meaning columns per page (power of two, 16..256).
REQ-002 The block SHALL have parameter PAGES, default 8, meaning pages per frame (1..16).
REQ-003 The block SHALL have parameter ADDR_W, default 10, meaning RAM address width (equal to log2(COLS*PAGES)).
REQ-004 The block SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset; it is synchronous and active-low.
REQ-006 The block SHALL have port init_done  in  1  panel initialisation complete; gates leaving IDLE.
REQ-007 The block SHALL have port start  in  1  one-cycle refresh request.
REQ-008 The block SHALL have port cont_mode  in  1  high: restart refresh automatically after each frame.
REQ-009 The block SHALL have ports rden  out  1, rdaddress  out  ADDR_W, ram_data  in  8: the frame-buffer read port.
REQ-010 The block SHALL have ports ena_write  out  1, data  out  8, write_done  in  1: the SPI byte-writer handshake.
REQ-011 The block SHALL have ports oled_dc  out  1 (0 command, 1 data), busy  out  1, frame_done  out  1 (one-cycle pulse).

Function
REQ-012 The FSM SHALL have states IDLE, CMD, CMD_WAIT, RD, RD_LAT, DAT, DAT_WAIT, NEXT, DONE.
REQ-013 In IDLE, start=1 with init_done=1 SHALL move the FSM to CMD on the next edge, with busy=1 from that cycle; start SHALL be ignored while busy=1 or init_done=0.
REQ-014 Each page SHALL begin with three commands at oled_dc=0: 8'hB0|page, 8'h00|col_start[3:0], 8'h10|col_start[7:4]; col_start SHALL be 0 unless windowing applies.
REQ-015 Each byte transfer SHALL work as follows: data/oled_dc are set, ena_write pulses high for exactly one cycle, and data/oled_dc stay stable until write_done is sampled high; the next byte SHALL NOT be issued in the same cycle as write_done.
REQ-016 Reading a data byte SHALL proceed as follows: RD asserts rden=1 for one cycle with rdaddress=page*COLS+col; ram_data is captured in RD_LAT, one cycle later; DAT then issues it with oled_dc=1.
REQ-017 Column and page counters SHALL advance in NEXT: col wraps from col_end to col_start while page increments; after the last column of the last page, the FSM SHALL go to DONE.
REQ-018 DONE SHALL pulse frame_done for one cycle; if cont_mode=1 and init_done=1 the FSM SHALL then go to CMD with page reset to page_start, otherwise to IDLE with busy=0.
REQ-019 write_done arriving outside CMD_WAIT/DAT_WAIT SHALL be ignored.
REQ-020 rdaddress SHALL hold its last value when rden=0.

Reset
REQ-021 rst_n=0 at a clock edge SHALL return the FSM to IDLE from any state, including mid-byte, and SHALL set rden=0, rdaddress=0, ena_write=0, oled_dc=0, data=0, busy=0, frame_done=0, and page/col counters to 0.

Configuration
REQ-022 With OLED_STREAM_WIN_EN defined, the block SHALL add inputs win_page_start/win_page_end (4 bits each) and win_col_start/win_col_end (8 bits each), latched at start.
REQ-023 With OLED_STREAM_WIN_EN defined, only the latched window SHALL be refreshed.
REQ-024 With OLED_STREAM_WIN_EN defined, an invalid window (start>end, page_end>=PAGES, or col_end>=COLS) SHALL cause no bytes to be sent and frame_done to pulse on the second cycle after start.
REQ-025 Without OLED_STREAM_WIN_EN, the window ports SHALL be absent and the full frame SHALL always be refreshed.

Structure
REQ-026 Package oled_pkg SHALL hold the state enum typedef and the constants CMD_PAGE_BASE=8'hB0, CMD_COL_LO=8'h00, CMD_COL_HI=8'h10 and CMDS_PER_PAGE=3.
REQ-027 Sub-module oled_stream_cursor SHALL implement the page/column counters, the wrap logic and the rdaddress computation.

Verification (bench uses COLS=16, PAGES=2, a RAM with 1-cycle latency holding mem[i]=i, and an SPI model asserting write_done 8 cycles after ena_write)
REQ-028 start pulse -> exactly 38 bytes (B0,00,10, 00..0F, B1,00,10, 10..1F) with oled_dc 0/1 as specified, then one frame_done pulse and busy=0.
REQ-029 cont_mode=1 held high -> a second frame begins without start, and frame_done pulses once per 38 bytes.
REQ-030 init_done=0 with start pulsed -> no ena_write, and busy stays 0.
REQ-031 rst_n=0 during the 20th byte's DAT_WAIT -> all outputs are 0 the next cycle, and a new start replays the frame from B0.
REQ-032 start repulsed while busy -> byte count is unchanged (38).
REQ-033 With OLED_STREAM_WIN_EN and window page 1..1, col 4..7 -> bytes B1,04,10,14,15,16,17, then frame_done; with window col 9..3 -> zero bytes and frame_done.
